// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file write port between the ALU and
// load writeback paths, each buffered by a small FIFO, with a pending-write map.
module regfile_write_arbiter #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic [ADDR_W-1:0]          alu_addr,
  input  logic [DATA_W-1:0]          alu_data,
  input  logic                       mem_valid,
  output logic                       mem_ready,
  input  logic [ADDR_W-1:0]          mem_addr,
  input  logic [DATA_W-1:0]          mem_data,
  output logic                       rw,
  output logic [ADDR_W-1:0]          d_addr,
  output logic [DATA_W-1:0]          data,
  output logic                       wr_src,
  output logic [(1<<ADDR_W)-1:0]     pending
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned NREG  = 1 << ADDR_W;
  localparam int unsigned NSRC  = 2;
  localparam logic        SRC_MEM = 1'b1;

  logic [ADDR_W-1:0] addr_q [NSRC][DEPTH];
  logic [ADDR_W-1:0] addr_d [NSRC][DEPTH];
  logic [DATA_W-1:0] data_q [NSRC][DEPTH];
  logic [DATA_W-1:0] data_d [NSRC][DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q [NSRC];
  logic [PTR_W-1:0]  wr_ptr_d [NSRC];
  logic [PTR_W-1:0]  rd_ptr_q [NSRC];
  logic [PTR_W-1:0]  rd_ptr_d [NSRC];
  logic [CNT_W-1:0]  cnt_q [NSRC];
  logic [CNT_W-1:0]  cnt_d [NSRC];
  logic              last_grant_q, last_grant_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] d_addr_q, d_addr_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              wr_src_q, wr_src_d;

  logic [NSRC-1:0]   in_valid;
  logic [ADDR_W-1:0] in_addr [NSRC];
  logic [DATA_W-1:0] in_data [NSRC];
  logic [NSRC-1:0]   full;
  logic [NSRC-1:0]   not_empty;
  logic [NSRC-1:0]   src_ready;
  logic [NSRC-1:0]   push;
  logic [NSRC-1:0]   pop;
  logic              grant_valid;
  logic              grant_src;
  logic [PTR_W-1:0]  pend_offs;
  logic [NREG-1:0]   pending_c;

  // Source-indexed view of the two request ports
  always_comb begin
    in_valid   = {mem_valid, alu_valid};
    in_addr[0] = alu_addr;
    in_addr[1] = mem_addr;
    in_data[0] = alu_data;
    in_data[1] = mem_data;
  end

  // Ready ignores valid and any same-cycle pop, so a full FIFO never bypasses
  always_comb begin
    full      = '0;
    not_empty = '0;
    src_ready = '0;
    push      = '0;
    for (int unsigned s = 0; s < NSRC; s++) begin
      full[s]      = (cnt_q[s] == CNT_W'(DEPTH));
      not_empty[s] = (cnt_q[s] != '0);
      src_ready[s] = !full[s] && !reset;
      push[s]      = in_valid[s] && src_ready[s];
    end
  end

  assign alu_ready = src_ready[0];
  assign mem_ready = src_ready[1];

  // Round-robin: on a tie the source not granted last time wins
  always_comb begin
    grant_valid = |not_empty;
    grant_src   = (not_empty[0] && not_empty[1]) ? ~last_grant_q : not_empty[1];
    pop         = '0;
    pop[0]      = grant_valid && !grant_src;
    pop[1]      = grant_valid && grant_src;
  end

  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    for (int unsigned s = 0; s < NSRC; s++) begin
      wr_ptr_d[s] = wr_ptr_q[s] + PTR_W'(push[s]);
      rd_ptr_d[s] = rd_ptr_q[s] + PTR_W'(pop[s]);
      cnt_d[s]    = cnt_q[s] + CNT_W'(push[s]) - CNT_W'(pop[s]);
      if (push[s]) begin
        addr_d[s][wr_ptr_q[s]] = in_addr[s];
        data_d[s][wr_ptr_q[s]] = in_data[s];
      end
    end
  end

  // Output stage: address/data/source hold when idle, only rw drops
  always_comb begin
    rw_d         = grant_valid;
    d_addr_d     = d_addr_q;
    data_out_d   = data_out_q;
    wr_src_d     = wr_src_q;
    last_grant_d = last_grant_q;
    if (grant_valid) begin
      d_addr_d     = addr_q[grant_src][rd_ptr_q[grant_src]];
      data_out_d   = data_q[grant_src][rd_ptr_q[grant_src]];
      wr_src_d     = grant_src;
      last_grant_d = grant_src;
    end
  end

  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned s = 0; s < NSRC; s++) begin
        wr_ptr_q[s] <= '0;
        rd_ptr_q[s] <= '0;
        cnt_q[s]    <= '0;
      end
      last_grant_q <= SRC_MEM;
      rw_q         <= 1'b0;
      d_addr_q     <= '0;
      data_out_q   <= '0;
      wr_src_q     <= 1'b0;
    end else begin
      for (int unsigned s = 0; s < NSRC; s++) begin
        wr_ptr_q[s] <= wr_ptr_d[s];
        rd_ptr_q[s] <= rd_ptr_d[s];
        cnt_q[s]    <= cnt_d[s];
      end
      last_grant_q <= last_grant_d;
      rw_q         <= rw_d;
      d_addr_q     <= d_addr_d;
      data_out_q   <= data_out_d;
      wr_src_q     <= wr_src_d;
    end
  end

  // Pending map: every occupied FIFO slot plus the write currently on the port
  always_comb begin
    pending_c = '0;
    pend_offs = '0;
    for (int unsigned s = 0; s < NSRC; s++) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pend_offs = PTR_W'(PTR_W'(i) - rd_ptr_q[s]);
        if (CNT_W'(pend_offs) < cnt_q[s]) begin
          pending_c[addr_q[s][i]] = 1'b1;
        end
      end
    end
    if (rw_q) begin
      pending_c[d_addr_q] = 1'b1;
    end
  end

  assign rw      = rw_q;
  assign d_addr  = d_addr_q;
  assign data    = data_out_q;
  assign wr_src  = wr_src_q;
  assign pending = pending_c;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus randomized traffic,
// each cycle compared against a queue-based model of the arbiter's behaviour.
module tb_regfile_write_arbiter;

  localparam int DEPTH = 2;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, mem_valid;
  logic        alu_ready, mem_ready;
  logic [4:0]  alu_addr, mem_addr;
  logic [31:0] alu_data, mem_data;
  logic        rw;
  logic [4:0]  d_addr;
  logic [31:0] data;
  logic        wr_src;
  logic [31:0] pending;

  regfile_write_arbiter #(.DEPTH(DEPTH), .ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .rw(rw), .d_addr(d_addr), .data(data), .wr_src(wr_src), .pending(pending)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_fail = 0;

  // Model: FIFO contents per source, stimulus scripts, output stage
  ent_t        mq[2][$];
  ent_t        src_q[2][$];
  bit          last_g;
  bit          e_rw;
  logic [4:0]  e_addr;
  logic [31:0] e_data;
  bit          e_src;
  logic [4:0]  mem_order[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ent_t mk(input logic [4:0] a, input logic [31:0] d);
    ent_t e;
    e.a = a;
    e.d = d;
    return e;
  endfunction

  function automatic logic [31:0] exp_pend();
    logic [31:0] p = '0;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < mq[s].size(); i++) p[mq[s][i].a] = 1'b1;
    if (e_rw) p[e_addr] = 1'b1;
    return p;
  endfunction

  // One clock: drive, check readies, advance the model at the edge, check outputs
  task automatic tick(input bit rst, input int vprob);
    bit   g[2];
    bit   acc[2];
    bit   n0, n1;
    int   gs;
    ent_t e;
    reset = rst;
    for (int s = 0; s < 2; s++)
      g[s] = (src_q[s].size() > 0) && ($urandom_range(99) < vprob);
    alu_valid = g[0];
    mem_valid = g[1];
    if (g[0]) begin alu_addr = src_q[0][0].a; alu_data = src_q[0][0].d; end
    else begin alu_addr = 5'($urandom); alu_data = $urandom; end
    if (g[1]) begin mem_addr = src_q[1][0].a; mem_data = src_q[1][0].d; end
    else begin mem_addr = 5'($urandom); mem_data = $urandom; end
    #1;
    chk("alu_ready", 64'(alu_ready), 64'(!rst && mq[0].size() < DEPTH));
    chk("mem_ready", 64'(mem_ready), 64'(!rst && mq[1].size() < DEPTH));
    @(posedge clk);
    if (rst) begin
      mq[0].delete();
      mq[1].delete();
      last_g = 1'b1;
      e_rw = 1'b0; e_addr = '0; e_data = '0; e_src = 1'b0;
    end else begin
      for (int s = 0; s < 2; s++) acc[s] = g[s] && (mq[s].size() < DEPTH);
      n0 = mq[0].size() > 0;
      n1 = mq[1].size() > 0;
      if (n0 && n1) gs = last_g ? 0 : 1;
      else if (n0)  gs = 0;
      else if (n1)  gs = 1;
      else          gs = -1;
      if (gs >= 0) begin
        e = mq[gs].pop_front();
        e_rw = 1'b1; e_addr = e.a; e_data = e.d; e_src = gs[0]; last_g = gs[0];
      end else begin
        e_rw = 1'b0;
      end
      for (int s = 0; s < 2; s++)
        if (acc[s]) mq[s].push_back(src_q[s].pop_front());
    end
    #1;
    chk("rw", 64'(rw), 64'(e_rw));
    chk("d_addr", 64'(d_addr), 64'(e_addr));
    chk("data", 64'(data), 64'(e_data));
    chk("wr_src", 64'(wr_src), 64'(e_src));
    chk("pending", 64'(pending), 64'(exp_pend()));
    if (rw === 1'b1 && wr_src === 1'b1) mem_order.push_back(d_addr);
  endtask

  task automatic clear_scripts();
    src_q[0].delete();
    src_q[1].delete();
  endtask

  initial begin
    reset = 1'b1;
    alu_valid = 1'b0; mem_valid = 1'b0;
    alu_addr = '0; mem_addr = '0; alu_data = '0; mem_data = '0;
    last_g = 1'b1; e_rw = 1'b0; e_addr = '0; e_data = '0; e_src = 1'b0;

    // Reset for two cycles, then release
    tick(1, 100);
    tick(1, 100);
    tick(0, 100);
    chk("post_reset_rw", 64'(rw), 64'd0);
    chk("post_reset_pending", 64'(pending), 64'd0);

    // Single ALU write
    src_q[0].push_back(mk(5'd5, 32'hDEADBEEF));
    tick(0, 100);
    chk("single_pend5_set", 64'(pending[5]), 64'd1);
    tick(0, 100);
    chk("single_rw", 64'(rw), 64'd1);
    chk("single_addr", 64'(d_addr), 64'd5);
    chk("single_data", 64'(data), 64'hDEADBEEF);
    chk("single_src", 64'(wr_src), 64'd0);
    tick(0, 100);
    chk("single_rw_done", 64'(rw), 64'd0);
    chk("single_pend5_clr", 64'(pending[5]), 64'd0);

    // Tie after reset, then saturated round-robin
    tick(1, 100);
    src_q[0].push_back(mk(5'd3, 32'h11));
    src_q[1].push_back(mk(5'd7, 32'h22));
    for (int i = 0; i < 8; i++) begin
      src_q[0].push_back(mk(5'(10 + i), 32'h100 + 32'(i)));
      src_q[1].push_back(mk(5'(20 + i), 32'h200 + 32'(i)));
    end
    tick(0, 100);
    tick(0, 100);
    chk("tie_first_addr", 64'(d_addr), 64'd3);
    chk("tie_first_src", 64'(wr_src), 64'd0);
    tick(0, 100);
    chk("tie_second_addr", 64'(d_addr), 64'd7);
    chk("tie_second_src", 64'(wr_src), 64'd1);
    for (int k = 0; k < 6; k++) begin
      tick(0, 100);
      chk("rr_rw", 64'(rw), 64'd1);
      chk("rr_alt", 64'(wr_src), 64'(k % 2));
    end
    clear_scripts();
    for (int k = 0; k < 8; k++) tick(0, 100);

    // MEM backpressure while ALU competes
    tick(1, 100);
    mem_order.delete();
    src_q[1].push_back(mk(5'd20, 32'hA0));
    src_q[1].push_back(mk(5'd21, 32'hA1));
    src_q[1].push_back(mk(5'd22, 32'hA2));
    for (int i = 0; i < 8; i++) src_q[0].push_back(mk(5'(i), 32'hB0 + 32'(i)));
    tick(0, 100);
    tick(0, 100);
    chk("bp_mem_ready_low", 64'(mem_ready), 64'd0);
    for (int k = 0; k < 14; k++) tick(0, 100);
    chk("bp_mem_count", 64'(mem_order.size()), 64'd3);
    if (mem_order.size() == 3) begin
      chk("bp_order0", 64'(mem_order[0]), 64'd20);
      chk("bp_order1", 64'(mem_order[1]), 64'd21);
      chk("bp_order2", 64'(mem_order[2]), 64'd22);
    end
    clear_scripts();

    // Reset while the port is busy and both FIFOs hold entries
    tick(1, 100);
    for (int i = 0; i < 4; i++) begin
      src_q[0].push_back(mk(5'(12 + i), 32'hC0 + 32'(i)));
      src_q[1].push_back(mk(5'(24 + i), 32'hD0 + 32'(i)));
    end
    tick(0, 100);
    tick(0, 100);
    tick(0, 100);
    chk("midrst_busy", 64'(rw), 64'd1);
    clear_scripts();
    tick(1, 100);
    chk("midrst_rw", 64'(rw), 64'd0);
    chk("midrst_pending", 64'(pending), 64'd0);
    for (int k = 0; k < 4; k++) begin
      tick(0, 100);
      chk("midrst_idle", 64'(rw), 64'd0);
    end

    // Two back-to-back writes to the same register
    src_q[0].push_back(mk(5'd9, 32'h1));
    src_q[0].push_back(mk(5'd9, 32'h2));
    for (int k = 0; k < 3; k++) begin
      tick(0, 100);
      chk("same_pend9_held", 64'(pending[9]), 64'd1);
    end
    tick(0, 100);
    chk("same_pend9_clr", 64'(pending[9]), 64'd0);

    // Randomized traffic with narrow address range and occasional reset
    for (int c = 0; c < 3000; c++) begin
      for (int s = 0; s < 2; s++)
        while (src_q[s].size() < 2)
          src_q[s].push_back(mk(5'($urandom_range(7)), $urandom));
      tick($urandom_range(99) == 0, 70);
    end

    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end

endmodule
